// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, the zero-register constant and the writeback request record
// used by the WB stage, the multi-cycle unit and the write-port scheduler.
package regfile_wb_scheduler_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
        reg_onehot    = '0;
        reg_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bus bundle around the write-port scheduler: issue check, both writeback
// sources, the register file write port and the debug scoreboard view.
// slave = the scheduler, master = the surrounding core (or a bench).
interface regfile_wb_scheduler_if;
    import regfile_wb_scheduler_pkg::*;

    logic                issue_valid;
    logic                issue_mc;
    logic [ADDR_W-1:0]   issue_dest;
    logic [ADDR_W-1:0]   issue_src1;
    logic [ADDR_W-1:0]   issue_src2;
    logic                issue_stall;

    logic                pipe_wb_valid;
    logic [ADDR_W-1:0]   pipe_wb_addr;
    logic [DATA_W-1:0]   pipe_wb_data;

    logic                mc_wb_valid;
    logic                mc_wb_ready;
    logic [ADDR_W-1:0]   mc_wb_addr;
    logic [DATA_W-1:0]   mc_wb_data;

    logic                RegWrite;
    logic [ADDR_W-1:0]   Write_address;
    logic [DATA_W-1:0]   Write_data;
    logic [NUM_REGS-1:0] pending;

    modport slave (
        input  issue_valid, issue_mc, issue_dest, issue_src1, issue_src2,
        input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        input  mc_wb_valid, mc_wb_addr, mc_wb_data,
        output issue_stall, mc_wb_ready,
        output RegWrite, Write_address, Write_data, pending
    );

    modport master (
        output issue_valid, issue_mc, issue_dest, issue_src1, issue_src2,
        output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        output mc_wb_valid, mc_wb_addr, mc_wb_data,
        input  issue_stall, mc_wb_ready,
        input  RegWrite, Write_address, Write_data, pending
    );

endinterface

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Pending-write scoreboard for multi-cycle destinations plus the RAW/WAW
// hazard compare. Register 0 never becomes pending.
// WB_CLEAR_BYPASS_EN: the hazard compare ignores the bit being cleared by a
// multi-cycle transfer in the same cycle, saving one stall cycle.
module regfile_scoreboard
    import regfile_wb_scheduler_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                issue_valid,
    input  logic                issue_accept_mc,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic [ADDR_W-1:0]   issue_src1,
    input  logic [ADDR_W-1:0]   issue_src2,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic                hazard,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] hazard_view;

    // set/clear masks; set wins over clear if both hit one bit, r0 is masked off
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_accept_mc && issue_dest != ZERO_REG)
            set_mask = reg_onehot(issue_dest);
        if (clr_en)
            clr_mask = reg_onehot(clr_addr);
        pending_nxt = ((pending_q & ~clr_mask) | set_mask) & ~reg_onehot(ZERO_REG);
    end

    // scoreboard register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pending_q <= '0;
        else
            pending_q <= pending_nxt;
    end

    // hazard compare against sources and destination
    always_comb begin
`ifdef WB_CLEAR_BYPASS_EN
        hazard_view = pending_q & ~clr_mask;
`else
        hazard_view = pending_q;
`endif
        hazard = issue_valid &
                 (hazard_view[issue_src1] | hazard_view[issue_src2] | hazard_view[issue_dest]);
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register file write-port scheduler: pipeline WB always wins the port, the
// multi-cycle unit takes it when the pipeline is idle. A saturating starvation
// counter throttles issue so the pipeline drains and the mc result gets in.
// Optional build macro: WB_CLEAR_BYPASS_EN (same-cycle hazard release on clear).
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic                  CLK,
    input logic                  RST,
    regfile_wb_scheduler_if.slave bus
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    wb_req_t             pipe_req;
    wb_req_t             mc_req;
    wb_req_t             grant;
    logic                mc_ready;
    logic                mc_xfer;
    logic [CNT_W-1:0]    starve_cnt;
    logic                starve;
    logic                hazard;
    logic                stall;
    logic                issue_accept_mc;
    logic                reg_write_q;
    logic [ADDR_W-1:0]   write_addr_q;
    logic [DATA_W-1:0]   write_data_q;
    logic [NUM_REGS-1:0] pending_w;

    assign pipe_req = '{valid: bus.pipe_wb_valid, addr: bus.pipe_wb_addr, data: bus.pipe_wb_data};
    assign mc_req   = '{valid: bus.mc_wb_valid,   addr: bus.mc_wb_addr,   data: bus.mc_wb_data};

    assign mc_ready = ~pipe_req.valid;
    assign mc_xfer  = mc_req.valid & mc_ready;

    // fixed-priority grant: pipeline first, then an accepted mc result
    always_comb begin
        grant = '0;
        if (pipe_req.valid)
            grant = pipe_req;
        else if (mc_xfer)
            grant = mc_req;
    end

    // registered write port; address/data hold when nothing is granted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else if (grant.valid) begin
            reg_write_q  <= (grant.addr != ZERO_REG);
            write_addr_q <= grant.addr;
            write_data_q <= grant.data;
        end else begin
            reg_write_q  <= 1'b0;
        end
    end

    // saturating count of consecutive refused mc cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            starve_cnt <= '0;
        else if (!mc_req.valid || mc_xfer)
            starve_cnt <= '0;
        else if (starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign starve          = (starve_cnt == STARVE_MAX);
    assign stall           = hazard | (bus.issue_valid & starve);
    assign issue_accept_mc = bus.issue_valid & ~stall & bus.issue_mc;

    regfile_scoreboard u_scoreboard (
        .CLK             (CLK),
        .RST             (RST),
        .issue_valid     (bus.issue_valid),
        .issue_accept_mc (issue_accept_mc),
        .issue_dest      (bus.issue_dest),
        .issue_src1      (bus.issue_src1),
        .issue_src2      (bus.issue_src2),
        .clr_en          (mc_xfer),
        .clr_addr        (mc_req.addr),
        .hazard          (hazard),
        .pending         (pending_w)
    );

    assign bus.mc_wb_ready   = mc_ready;
    assign bus.issue_stall   = stall;
    assign bus.RegWrite      = reg_write_q;
    assign bus.Write_address = write_addr_q;
    assign bus.Write_data    = write_data_q;
    assign bus.pending       = pending_w;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run against a register-level reference model of the write port,
// scoreboard and starvation rules.
module tb_regfile_wb_scheduler;
    import regfile_wb_scheduler_pkg::*;

    localparam int LIMIT = 4;

    logic CLK;
    logic RST;
    int   n_cmp  = 0;
    int   n_fail = 0;

    regfile_wb_scheduler_if bus ();

    regfile_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid   = 1'b0;
        bus.issue_mc      = 1'b0;
        bus.issue_dest    = '0;
        bus.issue_src1    = '0;
        bus.issue_src2    = '0;
        bus.pipe_wb_valid = 1'b0;
        bus.pipe_wb_addr  = '0;
        bus.pipe_wb_data  = '0;
        bus.mc_wb_valid   = 1'b0;
        bus.mc_wb_addr    = '0;
        bus.mc_wb_data    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        #3;
        n_cmp++;
        if (bus.RegWrite !== 1'b0 || bus.Write_address !== 5'd0 || bus.Write_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_port: got we=%b addr=%0d data=%h want 0/0/0",
                     bus.RegWrite, bus.Write_address, bus.Write_data);
        end
        tick();
        n_cmp++;
        if (bus.pending !== 32'd0 || bus.issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sb: got pending=%h stall=%b want 0/0", bus.pending, bus.issue_stall);
        end
        RST = 1'b0;
    endtask

    task automatic test_pipe_write();
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_wb_addr  = 5'd5;
        bus.pipe_wb_data  = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL pipe_latency: got we=%b before edge want 0", bus.RegWrite);
        end
        tick();
        bus.pipe_wb_valid = 1'b0;
        n_cmp++;
        if (bus.RegWrite !== 1'b1 || bus.Write_address !== 5'd5 || bus.Write_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL pipe_write: got we=%b addr=%0d data=%h want 1/5/deadbeef",
                     bus.RegWrite, bus.Write_address, bus.Write_data);
        end
        tick();
        n_cmp++;
        if (bus.RegWrite !== 1'b0 || bus.Write_address !== 5'd5 || bus.Write_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL pipe_hold: got we=%b addr=%0d data=%h want 0/5/deadbeef",
                     bus.RegWrite, bus.Write_address, bus.Write_data);
        end
    endtask

    task automatic test_arbitration();
        int hs = 0;
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_addr = 5'd3; bus.pipe_wb_data = 32'h11;
        bus.mc_wb_valid   = 1'b1; bus.mc_wb_addr   = 5'd4; bus.mc_wb_data   = 32'h22;
        #1;
        n_cmp++;
        if (bus.mc_wb_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_ready_low: got %b want 0", bus.mc_wb_ready);
        end
        if (bus.mc_wb_valid && bus.mc_wb_ready) hs++;
        tick();
        n_cmp++;
        if (bus.RegWrite !== 1'b1 || bus.Write_address !== 5'd3 || bus.Write_data !== 32'h11) begin
            n_fail++;
            $display("FAIL arb_pipe_first: got we=%b addr=%0d data=%h want 1/3/11",
                     bus.RegWrite, bus.Write_address, bus.Write_data);
        end
        bus.pipe_wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.mc_wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_ready_high: got %b want 1", bus.mc_wb_ready);
        end
        if (bus.mc_wb_valid && bus.mc_wb_ready) hs++;
        tick();
        bus.mc_wb_valid = 1'b0;
        n_cmp++;
        if (bus.RegWrite !== 1'b1 || bus.Write_address !== 5'd4 || bus.Write_data !== 32'h22) begin
            n_fail++;
            $display("FAIL arb_mc_second: got we=%b addr=%0d data=%h want 1/4/22",
                     bus.RegWrite, bus.Write_address, bus.Write_data);
        end
        tick();
        n_cmp++;
        if (hs !== 1 || bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_once: got handshakes=%0d we=%b want 1/0", hs, bus.RegWrite);
        end
    endtask

    task automatic test_hazard();
        bus.issue_valid = 1'b1; bus.issue_mc = 1'b1; bus.issue_dest = 5'd7;
        bus.issue_src1 = 5'd0;  bus.issue_src2 = 5'd0;
        #1;
        n_cmp++;
        if (bus.issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL haz_first_issue: got stall=%b want 0", bus.issue_stall);
        end
        tick();
        bus.issue_mc = 1'b0; bus.issue_dest = 5'd1; bus.issue_src1 = 5'd7;
        #1;
        n_cmp++;
        if (bus.pending !== 32'h80 || bus.issue_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL haz_raw: got pending=%h stall=%b want 00000080/1", bus.pending, bus.issue_stall);
        end
        tick();
        bus.mc_wb_valid = 1'b1; bus.mc_wb_addr = 5'd7; bus.mc_wb_data = 32'h77;
        #1;
        n_cmp++;
`ifdef WB_CLEAR_BYPASS_EN
        if (bus.issue_stall !== 1'b0 || bus.mc_wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL haz_clear_cycle: got stall=%b ready=%b want 0/1", bus.issue_stall, bus.mc_wb_ready);
        end
`else
        if (bus.issue_stall !== 1'b1 || bus.mc_wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL haz_clear_cycle: got stall=%b ready=%b want 1/1", bus.issue_stall, bus.mc_wb_ready);
        end
`endif
        tick();
        bus.mc_wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.issue_stall !== 1'b0 || bus.pending !== 32'd0 || bus.RegWrite !== 1'b1 || bus.Write_address !== 5'd7) begin
            n_fail++;
            $display("FAIL haz_after_clear: got stall=%b pending=%h we=%b addr=%0d want 0/0/1/7",
                     bus.issue_stall, bus.pending, bus.RegWrite, bus.Write_address);
        end
        bus.issue_valid = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        bus.issue_valid = 1'b1; bus.issue_mc = 1'b0;
        bus.issue_dest = 5'd3; bus.issue_src1 = 5'd1; bus.issue_src2 = 5'd2;
        bus.mc_wb_valid = 1'b1; bus.mc_wb_addr = 5'd12; bus.mc_wb_data = 32'hC0DE;
        for (int k = 0; k < 6; k++) begin
            bus.pipe_wb_valid = 1'b1;
            bus.pipe_wb_addr  = 5'($urandom_range(1, 31));
            bus.pipe_wb_data  = $urandom;
            #1;
            n_cmp++;
            if (bus.issue_stall !== (k >= LIMIT) || bus.mc_wb_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL starve_cycle%0d: got stall=%b ready=%b want %b/0",
                         k, bus.issue_stall, bus.mc_wb_ready, (k >= LIMIT));
            end
            tick();
        end
        bus.pipe_wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.issue_stall !== 1'b1 || bus.mc_wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_xfer: got stall=%b ready=%b want 1/1", bus.issue_stall, bus.mc_wb_ready);
        end
        tick();
        bus.mc_wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.issue_stall !== 1'b0 || bus.Write_address !== 5'd12 || bus.Write_data !== 32'hC0DE) begin
            n_fail++;
            $display("FAIL starve_release: got stall=%b addr=%0d data=%h want 0/12/c0de",
                     bus.issue_stall, bus.Write_address, bus.Write_data);
        end
        bus.issue_valid = 1'b0;
        tick();
    endtask

    task automatic test_r0();
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_addr = 5'd0; bus.pipe_wb_data = 32'hFFFF;
        tick();
        bus.pipe_wb_valid = 1'b0;
        n_cmp++;
        if (bus.RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_pipe: got we=%b want 0", bus.RegWrite);
        end
        bus.issue_valid = 1'b1; bus.issue_mc = 1'b1; bus.issue_dest = 5'd0;
        bus.issue_src1 = 5'd0; bus.issue_src2 = 5'd0;
        #1;
        n_cmp++;
        if (bus.issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_issue: got stall=%b want 0", bus.issue_stall);
        end
        tick();
        bus.issue_valid = 1'b0;
        bus.mc_wb_valid = 1'b1; bus.mc_wb_addr = 5'd0; bus.mc_wb_data = 32'h1234;
        #1;
        n_cmp++;
        if (bus.pending !== 32'd0 || bus.mc_wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_mc_hs: got pending=%h ready=%b want 0/1", bus.pending, bus.mc_wb_ready);
        end
        tick();
        bus.mc_wb_valid = 1'b0;
        n_cmp++;
        if (bus.RegWrite !== 1'b0 || bus.pending !== 32'd0) begin
            n_fail++;
            $display("FAIL r0_mc_write: got we=%b pending=%h want 0/0", bus.RegWrite, bus.pending);
        end
    endtask

    task automatic test_async_reset();
        bus.issue_valid = 1'b1; bus.issue_mc = 1'b1; bus.issue_dest = 5'd9;
        bus.issue_src1 = 5'd0; bus.issue_src2 = 5'd0;
        tick();
        bus.issue_mc = 1'b0; bus.issue_dest = 5'd2; bus.issue_src1 = 5'd9;
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_addr = 5'd6; bus.pipe_wb_data = 32'hABCD;
        bus.mc_wb_valid = 1'b1; bus.mc_wb_addr = 5'd9; bus.mc_wb_data = 32'h99;
        tick();
        tick();
        n_cmp++;
        if (bus.pending !== 32'h200 || bus.RegWrite !== 1'b1 || bus.issue_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_setup: got pending=%h we=%b stall=%b want 00000200/1/1",
                     bus.pending, bus.RegWrite, bus.issue_stall);
        end
        bus.issue_src1 = 5'd4;
        #2;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (bus.pending !== 32'd0 || bus.RegWrite !== 1'b0 || bus.Write_address !== 5'd0 ||
            bus.Write_data !== 32'd0 || bus.issue_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got pending=%h we=%b addr=%0d data=%h stall=%b want all 0",
                     bus.pending, bus.RegWrite, bus.Write_address, bus.Write_data, bus.issue_stall);
        end
        idle_inputs();
        tick();
        RST = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit              pend [NUM_REGS];
        int              starve_n = 0;
        bit              e_we = 0;
        int              e_addr = 0;
        logic [31:0]     e_data = '0;
        bit              mc_v = 0;
        int              mc_a = 0;
        logic [31:0]     mc_d = '0;
        bit              hz, e_stall, e_ready, xfer, acc;
        logic [31:0]     pend_vec;
        bit              byp_clr;

        for (int r = 0; r < NUM_REGS; r++) pend[r] = 0;
        RST = 1'b1;
        #2;
        RST = 1'b0;
        tick();

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!mc_v && $urandom_range(0, 99) < 35) begin
                mc_v = 1;
                mc_a = $urandom_range(0, 7);
                mc_d = $urandom;
            end
            bus.pipe_wb_valid = ($urandom_range(0, 99) < 45);
            bus.pipe_wb_addr  = 5'($urandom_range(0, 31));
            bus.pipe_wb_data  = $urandom;
            bus.mc_wb_valid   = mc_v;
            bus.mc_wb_addr    = 5'(mc_a);
            bus.mc_wb_data    = mc_d;
            bus.issue_valid   = ($urandom_range(0, 99) < 60);
            bus.issue_mc      = ($urandom_range(0, 1) == 1);
            bus.issue_dest    = 5'($urandom_range(0, 7));
            bus.issue_src1    = 5'($urandom_range(0, 7));
            bus.issue_src2    = 5'($urandom_range(0, 7));
            #1;

            e_ready = !bus.pipe_wb_valid;
            xfer    = mc_v && e_ready;
            hz = 0;
            if (bus.issue_valid) begin
                for (int r = 1; r < NUM_REGS; r++) begin
`ifdef WB_CLEAR_BYPASS_EN
                    byp_clr = xfer && (mc_a == r);
`else
                    byp_clr = 0;
`endif
                    if (pend[r] && !byp_clr &&
                        (bus.issue_src1 == r || bus.issue_src2 == r || bus.issue_dest == r))
                        hz = 1;
                end
            end
            e_stall = hz || (bus.issue_valid && starve_n == LIMIT);

            n_cmp++;
            if (bus.mc_wb_ready !== e_ready || bus.issue_stall !== e_stall) begin
                n_fail++;
                $display("FAIL rand_comb@%0d: got ready=%b stall=%b want %b/%b",
                         cyc, bus.mc_wb_ready, bus.issue_stall, e_ready, e_stall);
            end

            if (bus.pipe_wb_valid) begin
                e_we = (bus.pipe_wb_addr != 0);
                e_addr = bus.pipe_wb_addr;
                e_data = bus.pipe_wb_data;
            end else if (xfer) begin
                e_we = (mc_a != 0);
                e_addr = mc_a;
                e_data = mc_d;
            end else begin
                e_we = 0;
            end
            acc = bus.issue_valid && !e_stall && bus.issue_mc;
            if (xfer) pend[mc_a] = 0;
            if (acc && bus.issue_dest != 0) pend[bus.issue_dest] = 1;
            if (!mc_v || xfer) starve_n = 0;
            else if (starve_n < LIMIT) starve_n++;
            if (xfer) mc_v = 0;

            tick();
            pend_vec = '0;
            for (int r = 0; r < NUM_REGS; r++) pend_vec[r] = pend[r];
            n_cmp++;
            if (bus.RegWrite !== e_we || bus.Write_address !== 5'(e_addr) ||
                bus.Write_data !== e_data || bus.pending !== pend_vec) begin
                n_fail++;
                $display("FAIL rand_port@%0d: got we=%b addr=%0d data=%h pend=%h want %b/%0d/%h/%h",
                         cyc, bus.RegWrite, bus.Write_address, bus.Write_data, bus.pending,
                         e_we, e_addr, e_data, pend_vec);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_pipe_write();
        test_arbitration();
        test_hazard();
        test_starve();
        test_r0();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
